// File: rtl/spi_init_sequencer.sv
// Shares one 24-bit SPI master between a power-up command-table walker and a host port.
// Optional read-back verification of walker reads: define SPI_INIT_VERIFY_EN.
module spi_init_sequencer #(
    parameter int unsigned NUM_CMDS   = 8,
    parameter int unsigned START_HOLD = 4,
    parameter logic [15:0] TIMEOUT    = 16'd8000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_init_start,
    output logic [7:0] o_tbl_index,
    input  logic       i_tbl_op,
    input  logic [7:0] i_tbl_addr,
    input  logic [7:0] i_tbl_data,
    input  logic       i_host_req,
    input  logic       i_host_rw,
    input  logic [7:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic       o_host_ack,
    output logic [7:0] o_host_rdata,
    output logic       o_init_busy,
    output logic       o_init_done,
    output logic       o_err,
    output logic [7:0] o_err_index,
`ifdef SPI_INIT_VERIFY_EN
    output logic       o_mismatch,
`endif
    output logic       o_spi_start_w,
    output logic       o_spi_start_r,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_wdata,
    input  logic [7:0] i_spi_rdata,
    input  logic       i_spi_done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_NEXT, ST_READY, ST_ERROR
    } state_t;

    localparam logic [7:0]  LAST_INDEX   = 8'(NUM_CMDS - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(START_HOLD - 1);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_init_start_d;
    logic [15:0] r_cnt;
    logic        r_op;
    logic        r_host;
    logic [7:0]  r_tbl_index;
    logic [7:0]  r_spi_addr;
    logic [7:0]  r_spi_wdata;
    logic [7:0]  r_host_rdata;
    logic [7:0]  r_err_index;
    logic        r_host_ack;
    logic        r_init_busy;
    logic        r_init_done;
    logic        r_err;
    logic        w_init_rise;
    logic        w_walk_go;
    logic        w_host_go;
    logic        w_wait_done;
    logic        w_timeout;
    logic        w_verify_fail;

    assign w_init_rise = i_init_start & ~r_init_start_d;

`ifdef SPI_INIT_VERIFY_EN
    logic r_mismatch;
    assign o_mismatch    = r_mismatch;
    // Table data is still addressed by the current index while in NEXT.
    assign w_verify_fail = (r_state == ST_NEXT) && !r_host && r_op && (i_spi_rdata != i_tbl_data);
`else
    assign w_verify_fail = 1'b0;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_walk_go    = 1'b0;
        w_host_go    = 1'b0;
        w_wait_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_init_rise) begin
                    w_walk_go    = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: w_state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done was cleared by the master during ISSUE, so a high level here is fresh.
                if (i_spi_done) begin
                    w_wait_done  = 1'b1;
                    w_state_next = r_host ? ST_READY : ST_NEXT;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_ERROR;
                end
            end
            ST_NEXT: begin
                if (w_verify_fail) begin
                    w_state_next = ST_ERROR;
                end else if (r_tbl_index == LAST_INDEX) begin
                    w_state_next = ST_READY;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_READY: begin
                if (w_init_rise) begin
                    w_walk_go    = 1'b1;
                    w_state_next = ST_FETCH;
                end else if (i_host_req) begin
                    w_host_go    = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ERROR: begin
                if (w_init_rise) begin
                    w_walk_go    = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_init_start_d <= 1'b0;
            r_cnt          <= 16'd0;
            r_op           <= 1'b0;
            r_host         <= 1'b0;
            r_tbl_index    <= 8'd0;
            r_spi_addr     <= 8'd0;
            r_spi_wdata    <= 8'd0;
            r_host_rdata   <= 8'd0;
            r_err_index    <= 8'd0;
            r_host_ack     <= 1'b0;
            r_init_busy    <= 1'b0;
            r_init_done    <= 1'b0;
            r_err          <= 1'b0;
`ifdef SPI_INIT_VERIFY_EN
            r_mismatch     <= 1'b0;
`endif
        end else begin
            r_init_start_d <= i_init_start;
            r_host_ack     <= 1'b0;

            // One counter serves both the start-hold and the done timeout.
            if (w_state_next != r_state) begin
                r_cnt <= 16'd0;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_walk_go) begin
                r_tbl_index <= 8'd0;
                r_init_busy <= 1'b1;
                r_init_done <= 1'b0;
                r_err       <= 1'b0;
`ifdef SPI_INIT_VERIFY_EN
                r_mismatch  <= 1'b0;
`endif
            end

            if (r_state == ST_FETCH) begin
                r_op        <= i_tbl_op;
                r_host      <= 1'b0;
                r_spi_addr  <= i_tbl_addr;
                r_spi_wdata <= i_tbl_op ? 8'd0 : i_tbl_data;
            end

            if (w_host_go) begin
                r_op        <= i_host_rw;
                r_host      <= 1'b1;
                r_spi_addr  <= i_host_addr;
                r_spi_wdata <= i_host_rw ? 8'd0 : i_host_wdata;
            end

            if (w_wait_done && r_host) begin
                r_host_ack <= 1'b1;
                if (r_op) begin
                    r_host_rdata <= i_spi_rdata;
                end
            end

            if (r_state == ST_NEXT && !w_verify_fail) begin
                if (r_tbl_index == LAST_INDEX) begin
                    r_init_busy <= 1'b0;
                    r_init_done <= 1'b1;
                end else begin
                    r_tbl_index <= r_tbl_index + 8'd1;
                end
            end

            if (w_timeout || w_verify_fail) begin
                r_err       <= 1'b1;
                r_init_busy <= 1'b0;
                r_err_index <= (w_timeout && r_host) ? 8'hFF : r_tbl_index;
            end

`ifdef SPI_INIT_VERIFY_EN
            if (w_verify_fail) begin
                r_mismatch <= 1'b1;
            end
`endif
        end
    end

    assign o_spi_start_w = (r_state == ST_ISSUE) && !r_op;
    assign o_spi_start_r = (r_state == ST_ISSUE) && r_op;
    assign o_spi_addr    = r_spi_addr;
    assign o_spi_wdata   = r_spi_wdata;
    assign o_tbl_index   = r_tbl_index;
    assign o_host_ack    = r_host_ack;
    assign o_host_rdata  = r_host_rdata;
    assign o_init_busy   = r_init_busy;
    assign o_init_done   = r_init_done;
    assign o_err         = r_err;
    assign o_err_index   = r_err_index;

endmodule

// File: doc/spi_init_sequencer.md
Name: spi_init_sequencer

Overview:
- Controller in front of the 24-bit SPI master (slave-ID byte, address byte, data byte), sharing it between two requesters.
- Requester 1 is an internal power-up walker. It steps through an external command table of NUM_CMDS entries and issues each entry as an SPI write or read.
- Requester 2 is the host port. It is served only after the walker finishes.
- Sole driver of the master's start_w, start_r, addr and wdata. The master is a level-start, done-level-handshake block.

Parameters:
- NUM_CMDS, 8, number of table entries walked (1..255).
- START_HOLD, 4, cycles start_w/start_r held high per transaction (must be ≥3 to cover the master's 2-flop edge detect).
- TIMEOUT, 16'd8000, max cycles waiting for spi_done per transaction.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  rising edge (registered detect) starts the table walk
- tbl_index  out  8  current table entry index
- tbl_op  in  1  entry type, combinational from tbl_index: 0 write, 1 read
- tbl_addr  in  8  entry register address
- tbl_data  in  8  entry write data, or expected read data
- host_req  in  1  host request, level; sampled only in READY
- host_rw  in  1  0 write, 1 read
- host_addr  in  8  host register address
- host_wdata  in  8  host write data
- host_ack  out  1  1-cycle pulse when host transaction completes
- host_rdata  out  8  read result, valid from the host_ack cycle until the next host read
- init_busy  out  1  walk in progress
- init_done  out  1  walk finished without error; sticky
- err  out  1  timeout (or verify mismatch); sticky
- err_index  out  8  tbl_index at the failing entry; 8'hFF for a host timeout
- spi_start_w  out  1  to master start_w
- spi_start_r  out  1  to master start_r
- spi_addr  out  8  to master addr
- spi_wdata  out  8  to master wdata
- spi_rdata  in  8  from master rdata
- spi_done  in  1  from master done

Behaviour:
- Reset values: all outputs 0, except err_index = 8'h00. State = IDLE.
- FSM states: IDLE, FETCH, ISSUE, WAIT, NEXT, READY, ERROR.
- IDLE:
  - init_start rise → FETCH.
  - tbl_index ← 0, init_busy ← 1, init_done ← 0, err ← 0.
  - host_req is ignored.
- FETCH (1 cycle):
  - Latch tbl_op, tbl_addr, tbl_data into the spi_addr/spi_wdata/op registers. On a read, spi_wdata ← 0.
  - → ISSUE.
- ISSUE:
  - Drive spi_start_w (op=0) or spi_start_r (op=1) high for exactly START_HOLD cycles.
  - Then → WAIT.
  - spi_addr/spi_wdata stay stable from FETCH until WAIT exits.
- WAIT:
  - Count cycles from 0.
  - On spi_done = 1 → NEXT (walker) or READY (host).
  - If the count reaches TIMEOUT with spi_done still 0 → ERROR.
  - The master clears done 2 cycles after start rises. By WAIT entry done is 0, so the stale done=1 from a previous transaction is never mistaken for completion.
- NEXT (1 cycle):
  - If tbl_index == NUM_CMDS-1: → READY, init_busy ← 0, init_done ← 1.
  - Else: tbl_index + 1 → FETCH.
- READY:
  - host_req = 1 → latch host_rw/host_addr/host_wdata → ISSUE. The transaction is tagged as host.
  - On host-tagged completion:
    - host_ack pulses for 1 cycle on the WAIT→READY transition.
    - For reads, host_rdata ← spi_rdata on that cycle.
  - Host must drop host_req within one cycle of host_ack, or a new transaction is issued.
  - init_start rise in READY restarts the walk (→ IDLE behaviour), cancelling nothing: it is only sampled in READY.
- ERROR:
  - err ← 1, err_index set, init_busy ← 0, start outputs 0.
  - Stays here until an init_start rise → restart the walk with err cleared.
- Priority: the walker always owns the master while init_busy. Host requests are never accepted outside READY.
- init_start rising mid-walk (FETCH/ISSUE/WAIT/NEXT) is ignored.
- Reset asserted mid-transaction:
  - Immediately force the IDLE outputs (start lines 0).
  - The master is reset separately by the system.
- tbl_index never exceeds NUM_CMDS-1. There is no wrap.

Optional Feature:
- Macro: SPI_INIT_VERIFY_EN.
- Defined:
  - Walker read entries compare spi_rdata with tbl_data in NEXT.
  - On mismatch → ERROR, with err_index = tbl_index.
  - Adds output mismatch (1 bit, sticky, reset 0) distinguishing mismatch from timeout.
- Undefined:
  - Walker read entries execute, and the result is discarded.
  - No mismatch port.
  - Reads never cause ERROR except by timeout.

Test Plan:
- Table of 3 writes (0x10←0xA5, 0x11←0x5A, 0x12←0xFF), NUM_CMDS=3, init_start pulse, master model freq=100:
  - three start_w pulses of exactly 4 cycles with matching spi_addr/spi_wdata;
  - init_done=1, init_busy=0, err=0;
  - no start_r.
- After init, host_req read of addr 0x20, slave model returns 0x3C → single start_r, host_ack 1 cycle, host_rdata=0x3C.
- host_req asserted during the walk → no host transaction until init_done. Then exactly one host transaction, followed by host_ack.
- Slave model never completes on entry 1 → err=1 after 8000 WAIT cycles, err_index=1, start lines low. A later init_start restarts from tbl_index 0.
- SPI_INIT_VERIFY_EN defined, read entry expecting 0x42, slave returns 0x43 → err=1, mismatch=1, err_index=that entry.
- Reset asserted in the middle of ISSUE → all outputs return to reset values within the same cycle, state IDLE; a new init_start walks normally.
